// File: rtl/controlador_manobra.sv
// Drive-wheel, buzzer and status-LED controller for the vacuum robot: timed obstacle avoidance,
// retry limit and low-battery stop. Optional blinking buzzer enabled by macro BUZZER_PISCA_EN.
module controlador_manobra #(
  parameter int unsigned T_RE      = 8,
  parameter int unsigned T_GIRO    = 12,
  parameter int unsigned MAX_TENT  = 3,
  parameter int unsigned LARG_CONT = 8,
  parameter int unsigned PER_PISCA = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       liga,
  input  logic       f,
  input  logic       a,
  input  logic       d,
  input  logic       e,
  input  logic       bateria,
  output logic       saida_e,
  output logic       saida_d,
  output logic       re_e,
  output logic       re_d,
  output logic       sbuzzer,
  output logic       rgbverde,
  output logic       rgbverm,
  output logic       rgbazul,
  output logic [2:0] estado
);

  if (T_RE < 1 || T_RE > (2**LARG_CONT) - 1) begin : g_chk_re
    $error("T_RE out of range");
  end
  if (T_GIRO < 1 || T_GIRO > (2**LARG_CONT) - 1) begin : g_chk_giro
    $error("T_GIRO out of range");
  end
  if (MAX_TENT < 1 || MAX_TENT > 7) begin : g_chk_tent
    $error("MAX_TENT out of range");
  end
  if (PER_PISCA < 1) begin : g_chk_pisca
    $error("PER_PISCA must be at least 1");
  end

  typedef enum logic [2:0] {
    DESLIGADO = 3'd0,
    FRENTE    = 3'd1,
    GIRO_E    = 3'd2,
    GIRO_D    = 3'd3,
    RE        = 3'd4,
    BATERIA   = 3'd5,
    BLOQUEADO = 3'd6,
    INVALIDO  = 3'd7
  } estado_t;

  localparam logic [LARG_CONT-1:0] FIM_GIRO  = LARG_CONT'(T_GIRO - 1);
  localparam logic [LARG_CONT-1:0] FIM_RE    = LARG_CONT'(T_RE - 1);
  localparam logic [2:0]           TENT_MAX  = 3'(MAX_TENT);

  estado_t              estado_q, prox;
  logic [LARG_CONT-1:0] timer_q, timer_prox;
  logic [2:0]           tent_q, tent_prox, tent_inc;
  logic                 cronometrado, buzz_alarme;
  logic                 saida_e_p, saida_d_p, re_e_p, re_d_p;
  logic                 sbuzzer_p, verde_p, verm_p, azul_p;

  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q <= DESLIGADO;
      timer_q  <= '0;
      tent_q   <= '0;
    end else begin
      estado_q <= prox;
      timer_q  <= timer_prox;
      tent_q   <= tent_prox;
    end
  end

  always_comb begin
    prox      = estado_q;
    tent_prox = tent_q;
    tent_inc  = (tent_q >= TENT_MAX) ? TENT_MAX : tent_q + 3'd1;

    if (estado_q == DESLIGADO || (estado_q == FRENTE && !f)) tent_prox = '0;

    if (!liga) begin
      prox = DESLIGADO;
    end else begin
      unique case (estado_q)
        DESLIGADO: prox = bateria ? BATERIA : FRENTE;
        FRENTE: begin
          if (bateria)  prox = BATERIA;
          else if (f)   prox = !e ? GIRO_E : (!d ? GIRO_D : RE);
        end
        GIRO_E, GIRO_D: begin
          if (bateria) begin
            prox = BATERIA;
          end else if (timer_q == FIM_GIRO) begin
            if (!f) begin
              prox = FRENTE;
            end else begin
              tent_prox = tent_inc;
              prox      = (tent_inc == TENT_MAX) ? BLOQUEADO : RE;
            end
          end
        end
        // Rear obstacle cuts the reversal short; expiry and abort share one path.
        RE: begin
          if (bateria)                        prox = BATERIA;
          else if (timer_q == FIM_RE || a)    prox = e ? GIRO_D : GIRO_E;
        end
        BATERIA, BLOQUEADO: prox = estado_q;
        default: prox = DESLIGADO;
      endcase
    end
  end

  always_comb begin
    cronometrado = (prox == GIRO_E) || (prox == GIRO_D) || (prox == RE);
    timer_prox   = '0;
    if (cronometrado && prox == estado_q)
      timer_prox = (timer_q == '1) ? timer_q : timer_q + LARG_CONT'(1);
  end

`ifdef BUZZER_PISCA_EN
  localparam int unsigned        LARG_PISCA = (PER_PISCA > 1) ? $clog2(PER_PISCA) : 1;
  localparam logic [LARG_PISCA-1:0] FIM_PISCA = LARG_PISCA'(PER_PISCA - 1);

  logic [LARG_PISCA-1:0] pisca_q, pisca_prox;
  logic                  fase_q, fase_prox;

  // Phase restarts high on every state change so each alarm begins with a beep.
  always_comb begin
    pisca_prox = '0;
    fase_prox  = 1'b1;
    if (prox == estado_q) begin
      if (pisca_q == FIM_PISCA) begin
        pisca_prox = '0;
        fase_prox  = ~fase_q;
      end else begin
        pisca_prox = pisca_q + LARG_PISCA'(1);
        fase_prox  = fase_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pisca_q <= '0;
      fase_q  <= 1'b1;
    end else begin
      pisca_q <= pisca_prox;
      fase_q  <= fase_prox;
    end
  end

  assign buzz_alarme = fase_prox;
`else
  assign buzz_alarme = 1'b1;
`endif

  always_comb begin
    {saida_e_p, saida_d_p, re_e_p, re_d_p} = '0;
    {sbuzzer_p, verde_p, verm_p, azul_p}   = '0;
    unique case (prox)
      FRENTE:    {saida_e_p, saida_d_p, verde_p} = '1;
      GIRO_E:    {saida_d_p, re_e_p, verm_p}     = '1;
      GIRO_D:    {saida_e_p, re_d_p, azul_p}     = '1;
      RE:        {re_e_p, re_d_p, verm_p, azul_p} = '1;
      BATERIA: begin
        sbuzzer_p = buzz_alarme;
        verm_p    = 1'b1;
      end
      BLOQUEADO: begin
        sbuzzer_p                  = buzz_alarme;
        {verde_p, verm_p, azul_p}  = '1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      {saida_e, saida_d, re_e, re_d}         <= '0;
      {sbuzzer, rgbverde, rgbverm, rgbazul}  <= '0;
    end else begin
      {saida_e, saida_d, re_e, re_d}         <= {saida_e_p, saida_d_p, re_e_p, re_d_p};
      {sbuzzer, rgbverde, rgbverm, rgbazul}  <= {sbuzzer_p, verde_p, verm_p, azul_p};
    end
  end

  assign estado = estado_q;

endmodule

// File: tb/tb_controlador_manobra.sv
// Self-checking bench for controlador_manobra: directed scenarios plus randomized traffic
// compared against a cycle-counting behavioural model of the manoeuvre rules.
module tb_controlador_manobra;

  localparam int T_RE = 8, T_GIRO = 12, MAX_TENT = 3, PER_PISCA = 4;

  logic clk = 1'b0;
  logic rst, liga, f, a, d, e, bateria;
  logic saida_e, saida_d, re_e, re_d, sbuzzer, rgbverde, rgbverm, rgbazul;
  logic [2:0] estado;

  int checks = 0;
  int failures = 0;

  int m_st, m_cyc, m_tent;

  controlador_manobra #(
    .T_RE(T_RE), .T_GIRO(T_GIRO), .MAX_TENT(MAX_TENT), .LARG_CONT(8), .PER_PISCA(PER_PISCA)
  ) dut (
    .clk(clk), .rst(rst), .liga(liga), .f(f), .a(a), .d(d), .e(e), .bateria(bateria),
    .saida_e(saida_e), .saida_d(saida_d), .re_e(re_e), .re_d(re_d), .sbuzzer(sbuzzer),
    .rgbverde(rgbverde), .rgbverm(rgbverm), .rgbazul(rgbazul), .estado(estado)
  );

  always #5 clk = ~clk;

  // Model: state code plus number of cycles already spent in that state.
  task automatic model_step();
    int nx;
    if (rst) begin
      m_st = 0; m_cyc = 0; m_tent = 0;
      return;
    end
    nx = m_st;
    if (m_st == 0 || (m_st == 1 && !f)) m_tent = 0;
    if (!liga) nx = 0;
    else begin
      case (m_st)
        0: nx = bateria ? 5 : 1;
        1: if (bateria) nx = 5;
           else if (f) nx = !e ? 2 : (!d ? 3 : 4);
        2, 3: if (bateria) nx = 5;
              else if (m_cyc + 1 == T_GIRO) begin
                if (!f) nx = 1;
                else begin
                  m_tent = (m_tent + 1 > MAX_TENT) ? MAX_TENT : m_tent + 1;
                  nx = (m_tent == MAX_TENT) ? 6 : 4;
                end
              end
        4: if (bateria) nx = 5;
           else if (m_cyc + 1 == T_RE || a) nx = e ? 3 : 2;
        5, 6: nx = m_st;
        default: nx = 0;
      endcase
    end
    m_cyc = (nx == m_st) ? m_cyc + 1 : 0;
    m_st  = nx;
  endtask

  function automatic logic [10:0] model_out();
    logic [7:0] o;
    case (m_st)
      1: o = 8'b1100_0100;
      2: o = 8'b0110_0010;
      3: o = 8'b1001_0001;
      4: o = 8'b0011_0011;
      5: o = 8'b0000_1010;
      6: o = 8'b0000_1111;
      default: o = 8'b0000_0000;
    endcase
`ifdef BUZZER_PISCA_EN
    if (m_st == 5 || m_st == 6) o[3] = ((m_cyc / PER_PISCA) % 2) == 0;
`endif
    return {3'(m_st), o};
  endfunction

  function automatic logic [10:0] dut_out();
    return {estado, saida_e, saida_d, re_e, re_d, sbuzzer, rgbverde, rgbverm, rgbazul};
  endfunction

  task automatic clk_step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_in(input logic l, input logic ff, input logic ee, input logic dd,
                        input logic aa, input logic bb);
    liga = l; f = ff; e = ee; d = dd; a = aa; bateria = bb;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0);
    clk_step();
    clk_step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (dut_out() !== 11'd0) begin
      failures++;
      $display("FAIL reset_state got=%b exp=%b", dut_out(), 11'd0);
    end
    liga = 1'b1;
    clk_step();
    checks++;
    if (dut_out() !== 11'b001_1100_0100 || dut_out() !== model_out()) begin
      failures++;
      $display("FAIL startup_frente got=%b exp=%b", dut_out(), 11'b001_1100_0100);
    end
  endtask

  task automatic test_giro_e();
    int n;
    do_reset();
    set_in(1, 0, 0, 0, 0, 0);
    clk_step();
    f = 1'b1;
    clk_step();
    f = 1'b0;
    n = 0;
    while (estado == 3'd2 && n < 40) begin
      checks++;
      if (dut_out() !== model_out()) begin
        failures++;
        $display("FAIL giro_e_cycle%0d got=%b exp=%b", n, dut_out(), model_out());
      end
      n++;
      clk_step();
    end
    checks++;
    if (n != T_GIRO || estado !== 3'd1) begin
      failures++;
      $display("FAIL giro_e_length got=%0d/estado=%0d exp=%0d/estado=1", n, estado, T_GIRO);
    end
  endtask

  task automatic test_bloqueio();
    int n;
    do_reset();
    set_in(1, 0, 0, 0, 0, 0);
    clk_step();
    set_in(1, 1, 1, 1, 0, 0);
    n = 0;
    while (estado !== 3'd6 && n < 120) begin
      clk_step();
      n++;
      checks++;
      if (dut_out() !== model_out()) begin
        failures++;
        $display("FAIL bloqueio_seq%0d got=%b exp=%b", n, dut_out(), model_out());
      end
    end
    checks++;
    if (n != 1 + 3 * (T_RE + T_GIRO)) begin
      failures++;
      $display("FAIL bloqueio_latency got=%0d exp=%0d", n, 1 + 3 * (T_RE + T_GIRO));
    end
    checks++;
    if ({sbuzzer, rgbverde, rgbverm, rgbazul, saida_e, saida_d, re_e, re_d} !== 8'b1111_0000) begin
      failures++;
      $display("FAIL bloqueio_outputs got=%b exp=%b",
               {sbuzzer, rgbverde, rgbverm, rgbazul, saida_e, saida_d, re_e, re_d}, 8'b1111_0000);
    end
  endtask

  task automatic test_re_abort();
    do_reset();
    set_in(1, 0, 0, 0, 0, 0);
    clk_step();
    set_in(1, 1, 1, 1, 0, 0);
    clk_step();
    set_in(1, 0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      clk_step();
      checks++;
      if (estado !== 3'd4 || dut_out() !== model_out()) begin
        failures++;
        $display("FAIL re_hold%0d got=%b exp=%b", i, dut_out(), model_out());
      end
    end
    a = 1'b1;
    clk_step();
    checks++;
    if (estado !== 3'd3 || dut_out() !== model_out()) begin
      failures++;
      $display("FAIL re_abort got=%b exp=%b", dut_out(), model_out());
    end
  endtask

  task automatic test_bateria();
    do_reset();
    set_in(1, 0, 0, 0, 0, 0);
    clk_step();
    f = 1'b1;
    clk_step();
    f = 1'b0;
    clk_step();
    bateria = 1'b1;
    clk_step();
    checks++;
    if (estado !== 3'd5 || dut_out() !== model_out()) begin
      failures++;
      $display("FAIL bateria_entry got=%b exp=%b", dut_out(), model_out());
    end
    bateria = 1'b0;
    for (int i = 0; i < 3; i++) begin
      clk_step();
      checks++;
      if (estado !== 3'd5 || dut_out() !== model_out()) begin
        failures++;
        $display("FAIL bateria_sticky%0d got=%b exp=%b", i, dut_out(), model_out());
      end
    end
    liga = 1'b0;
    clk_step();
    checks++;
    if (dut_out() !== 11'd0) begin
      failures++;
      $display("FAIL bateria_desliga got=%b exp=%b", dut_out(), 11'd0);
    end
  endtask

  task automatic test_pisca();
    logic [15:0] got, exp_pat;
`ifdef BUZZER_PISCA_EN
    exp_pat = 16'b1111_0000_1111_0000;
`else
    exp_pat = 16'hFFFF;
`endif
    do_reset();
    set_in(1, 0, 0, 0, 0, 1);
    got = '0;
    for (int i = 15; i >= 0; i--) begin
      clk_step();
      got[i] = sbuzzer;
    end
    checks++;
    if (got !== exp_pat) begin
      failures++;
      $display("FAIL buzzer_pattern got=%b exp=%b", got, exp_pat);
    end
    rst = 1'b1;
    clk_step();
    rst = 1'b0;
    checks++;
    if (dut_out() !== 11'd0) begin
      failures++;
      $display("FAIL rst_mid_alarm got=%b exp=%b", dut_out(), 11'd0);
    end
  endtask

  task automatic test_rst_mid_manobra();
    do_reset();
    set_in(1, 0, 0, 0, 0, 0);
    clk_step();
    set_in(1, 1, 1, 1, 0, 0);
    clk_step();
    clk_step();
    rst = 1'b1;
    clk_step();
    rst = 1'b0;
    checks++;
    if (dut_out() !== 11'd0) begin
      failures++;
      $display("FAIL rst_mid_re got=%b exp=%b", dut_out(), 11'd0);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst     = ($urandom_range(0, 199) == 0);
      liga    = ($urandom_range(0, 99) != 0);
      bateria = ($urandom_range(0, 149) == 0);
      f       = ($urandom_range(0, 9) < 4);
      e       = $urandom_range(0, 1);
      d       = $urandom_range(0, 1);
      a       = ($urandom_range(0, 19) == 0);
      clk_step();
      checks++;
      if (dut_out() !== model_out()) begin
        failures++;
        $display("FAIL random_cycle%0d got=%b exp=%b", i, dut_out(), model_out());
      end
      checks++;
      if ((saida_e && re_e) || (saida_d && re_d)) begin
        failures++;
        $display("FAIL wheel_exclusive cycle%0d got=%b%b%b%b exp=no_conflict",
                 i, saida_e, re_e, saida_d, re_d);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0);
    m_st = 0; m_cyc = 0; m_tent = 0;
    test_reset();
    test_giro_e();
    test_bloqueio();
    test_re_abort();
    test_bateria();
    test_pisca();
    test_rst_mid_manobra();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
